rx_frame_ctrl: RTL and testbench

- Serial receive controller for the UART-style RX path; sits directly beside the bit timer.
- Detects the start bit on the synchronized serial line and drives `enable_timer` to the timer.
- Consumes the timer's `shift_strobe` and `packet_done`: captures 8 data bits plus the stop bit, validates the stop bit and presents the byte to the downstream consumer with ready/error flags.

---
 rtl/rx_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART-style receive framing controller.
// Synchronizes the serial line, detects the start bit, runs the external bit
// timer, collects DATA_BITS data bits plus the stop bit on the timer strobes,
// validates the stop bit and presents the byte with ready/error flags.
module rx_frame_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 shift_strobe,
    input  logic                 packet_done,
    input  logic                 data_read,
    output logic                 enable_timer,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        CHECK,
        LOAD
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sample_q;
    logic                    hist_q;
    logic [SYNC_STAGES+1:0]  primed_q;
    logic [DATA_BITS:0]      sreg_q;
    logic                    enable_q;
    logic [DATA_BITS-1:0]    rx_data_q;
    logic                    data_ready_q;
    logic                    framing_error_q;
    logic                    overrun_error_q;
    logic                    start_edge;

    // First synchronizer flop samples the asynchronous line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q[0] <= 1'b1;
        end else begin
            sync_q[0] <= serial_in;
        end
    end

    // Remaining synchronizer stages.
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            // Stage gi copies stage gi-1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q[gi] <= 1'b1;
                end else begin
                    sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    // Current/previous synchronized sample for start-bit edge detection.
    // primed_q marks when hist_q holds a genuine line observation rather than
    // the reset preset, so a line that is already low at reset release is not
    // mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= 1'b1;
            hist_q   <= 1'b1;
            primed_q <= '0;
        end else begin
            sample_q <= sync_q[SYNC_STAGES-1];
            hist_q   <= sample_q;
            primed_q <= {primed_q[SYNC_STAGES:0], 1'b1};
        end
    end

    assign start_edge = (state_q == IDLE) && primed_q[SYNC_STAGES+1]
                        && hist_q && !sample_q;

    // Frame FSM with registered timer enable, data and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            enable_q        <= 1'b0;
            sreg_q          <= '1;
            rx_data_q       <= '0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            // A read acknowledges the byte everywhere except LOAD, where the
            // freshly loaded byte keeps data_ready set.
            if (data_read && (state_q != LOAD)) begin
                data_ready_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    enable_q <= 1'b0;
                    if (start_edge) begin
                        state_q         <= RECEIVE;
                        enable_q        <= 1'b1;
                        framing_error_q <= 1'b0;
                        overrun_error_q <= 1'b0;
                        sreg_q          <= '1;
                    end
                end
                RECEIVE: begin
                    // packet_done takes priority; late strobes are ignored.
                    if (packet_done) begin
                        state_q  <= CHECK;
                        enable_q <= 1'b0;
                    end else if (shift_strobe) begin
                        sreg_q <= {sample_q, sreg_q[DATA_BITS:1]};
                    end
                end
                CHECK: begin
                    enable_q <= 1'b0;
                    if (sreg_q[DATA_BITS]) begin
                        state_q <= LOAD;
                    end else begin
                        framing_error_q <= 1'b1;
                        state_q         <= IDLE;
                    end
                end
                LOAD: begin
                    rx_data_q    <= sreg_q[DATA_BITS-1:0];
                    data_ready_q <= 1'b1;
                    if (data_ready_q && !data_read) begin
                        overrun_error_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    enable_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign enable_timer  = enable_q;
    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Testbench for rx_frame_ctrl: bit-timer model, directed vector table,
// randomized frames against a frame-level reference model, and hand-written
// sequences for mid-frame reset and a line held low out of reset.
module tb_rx_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       shift_strobe;
    logic       packet_done;
    logic       data_read;
    logic       enable_timer;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;

    int checks = 0;
    int errors = 0;

    // Frame-level reference state.
    logic [7:0] m_data;
    bit         m_ready;
    bit         m_fe;
    bit         m_oe;

    typedef struct {
        logic [7:0] d;
        bit         stop;
        bit         rd_load;
        bit         rd_after;
        logic [7:0] exp_data;
        bit         exp_ready;
        bit         exp_fe;
        bit         exp_oe;
    } vec_t;

    vec_t vecs[9];

    rx_frame_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .shift_strobe  (shift_strobe),
        .packet_done   (packet_done),
        .data_read     (data_read),
        .enable_timer  (enable_timer),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit timer model: one strobe every 10 cycles while enabled, then
    // packet_done from the cycle after the 9th strobe until enable drops.
    initial begin
        int tcnt;
        int nstrobe;
        tcnt = 0;
        nstrobe = 0;
        shift_strobe = 1'b0;
        packet_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!enable_timer) begin
                tcnt = 0;
                nstrobe = 0;
                shift_strobe = 1'b0;
                packet_done = 1'b0;
            end else begin
                shift_strobe = 1'b0;
                if (nstrobe == 9) begin
                    packet_done = 1'b1;
                end else begin
                    tcnt++;
                    if (tcnt == 10) begin
                        tcnt = 0;
                        shift_strobe = 1'b1;
                        nstrobe++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_oe    = 1'b0;
    endtask

    // Drive one frame (start, 8 data LSB first, stop, 10 cycles each) and
    // check handshake timing around packet_done when a completion is expected.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit rd_load,
                              input bit expect_done, input bit prior_ready);
        bit line[10];
        int c_pd;
        c_pd = -1;
        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[i+1] = d[i];
        line[9] = stop;
        for (int cyc = 0; cyc < 108; cyc++) begin
            @(posedge clk);
            #2;
            serial_in = (cyc < 100) ? line[cyc/10] : 1'b1;
            data_read = 1'b0;
            if (c_pd < 0 && packet_done) c_pd = cyc;
            if (expect_done && c_pd >= 0) begin
                if (cyc == c_pd + 1) chk("enable_low_in_check", 32'(enable_timer), 32'(0));
                if (cyc == c_pd + 2) begin
                    chk("ready_before_load", 32'(data_ready), 32'(prior_ready));
                    if (rd_load) data_read = 1'b1;
                end
                if (cyc == c_pd + 3)
                    chk("ready_two_after_done", 32'(data_ready), 32'(stop ? 1'b1 : prior_ready));
            end
        end
        if (expect_done) chk("done_cycle", 32'(c_pd), 32'(94));
    endtask

    task automatic pulse_read();
        @(posedge clk);
        #2;
        data_read = 1'b1;
        @(posedge clk);
        #2;
        data_read = 1'b0;
    endtask

    // Full frame transaction: drive, optional read afterwards, update model.
    task automatic run_frame(input logic [7:0] d, input bit stop, input bit rd_load,
                             input bit rd_after);
        send_frame(d, stop, rd_load, 1'b1, m_ready);
        m_fe = 1'b0;
        m_oe = 1'b0;
        if (stop) begin
            if (m_ready && !rd_load) m_oe = 1'b1;
            m_ready = 1'b1;
            m_data  = d;
        end else begin
            m_fe = 1'b1;
        end
        if (rd_after) begin
            pulse_read();
            m_ready = 1'b0;
        end
        $display("frame d=%02h stop=%0d rd_load=%0d rd_after=%0d -> rx_data=%02h ready=%0d fe=%0d oe=%0d",
                 d, stop, rd_load, rd_after, rx_data, data_ready, framing_error, overrun_error);
    endtask

    task automatic chk_outputs(input string tag, input logic [7:0] ed, input bit er,
                               input bit ef, input bit eo);
        chk({tag, ".rx_data"}, 32'(rx_data), 32'(ed));
        chk({tag, ".data_ready"}, 32'(data_ready), 32'(er));
        chk({tag, ".framing_error"}, 32'(framing_error), 32'(ef));
        chk({tag, ".overrun_error"}, 32'(overrun_error), 32'(eo));
        chk({tag, ".enable_timer"}, 32'(enable_timer), 32'(0));
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hAA, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        serial_in = 1'b1;
        data_read = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].d, vecs[i].stop, vecs[i].rd_load, vecs[i].rd_after);
            chk_outputs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ready,
                        vecs[i].exp_fe, vecs[i].exp_oe);
        end

        // Randomized frames against the reference model.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] rd;
            bit rs, rl, ra;
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rl = rs && ($urandom_range(0, 1) == 1);
            ra = ($urandom_range(0, 1) == 1);
            run_frame(rd, rs, rl, ra);
            chk_outputs($sformatf("rand%0d", i), m_data, m_ready, m_fe, m_oe);
        end

        // Reset one cycle after the 4th strobe of frame 0xFF.
        run_frame(8'h77, 1'b1, 1'b0, 1'b0);
        chk_outputs("pre_abort", m_data, m_ready, m_fe, m_oe);
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
            begin
                int n;
                int waited;
                n = 0;
                waited = 0;
                while (n < 4 && waited < 200) begin
                    @(posedge clk);
                    #2;
                    waited++;
                    if (shift_strobe) n++;
                end
                chk("fourth_strobe_seen", 32'(n), 32'(4));
                @(posedge clk);
                #2;
                rst = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
                chk_outputs("abort_reset", 8'h00, 1'b0, 1'b0, 1'b0);
            end
        join
        model_reset();
        chk_outputs("no_partial_load", m_data, m_ready, m_fe, m_oe);
        $display("abort frame d=ff -> rx_data=%02h ready=%0d", rx_data, data_ready);
        run_frame(8'h81, 1'b1, 1'b0, 1'b0);
        chk_outputs("after_abort", 8'h81, 1'b1, 1'b0, 1'b0);

        // Line held low out of reset: no frame until it goes high then low.
        serial_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        begin
            int hits;
            hits = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                #2;
                if (enable_timer) hits++;
            end
            chk("no_start_low_line", 32'(hits), 32'(0));
        end
        $display("line low from reset -> enable_timer=%0d ready=%0d", enable_timer, data_ready);
        serial_in = 1'b1;
        repeat (10) @(posedge clk);
        run_frame(8'h42, 1'b1, 1'b0, 1'b0);
        chk_outputs("after_low_line", 8'h42, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
